// File: rtl/prefix_adder_pkg.sv
// Shared KPG encoding, prefix combine operator and latency helpers for the
// pipelined prefix adder and its bench.
package prefix_adder_pkg;

  typedef enum logic [1:0] {
    KPG_KILL = 2'b00,
    KPG_PROP = 2'b01,
    KPG_GEN  = 2'b11
  } kpg_e;

  // Upper group dominates unless it merely propagates the lower one.
  function automatic logic [1:0] kpg_combine(input logic [1:0] hi, input logic [1:0] lo);
    return (hi == KPG_PROP) ? lo : hi;
  endfunction

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned lat(input int unsigned width, input int unsigned reg_every);
    int unsigned levels;
    levels = clog2(width);
    return (levels + reg_every - 1) / reg_every + 1;
  endfunction

endpackage

// File: rtl/kpg_prefix_level.sv
// One combinational Kogge-Stone level: bit i absorbs bit i-DIST.
module kpg_prefix_level
  import prefix_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIST  = 1
) (
  input  logic [2*WIDTH-1:0] kpg_in,
  output logic [2*WIDTH-1:0] kpg_out
);

  always_comb begin
    kpg_out = kpg_in;
    for (int unsigned i = DIST; i < WIDTH; i++) begin
      kpg_out[2*i +: 2] = kpg_combine(kpg_in[2*i +: 2], kpg_in[2*(i-DIST) +: 2]);
    end
  end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control and
// sum, carry-out, signed-overflow and zero flags.
module pipelined_prefix_adder
  import prefix_adder_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned REG_EVERY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned LEVELS = clog2(WIDTH);

  typedef struct packed {
    logic             valid;
    logic             c0;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
  } side_t;

  logic               en;
  logic               accept;
  logic [WIDTH-1:0]   b_eff;
  logic               c0_eff;
  logic [2*WIDTH-1:0] kpg_enc;
  logic [2*WIDTH-1:0] s0_kpg;
  side_t              s0_side;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;
  assign b_eff    = sub ? ~b : b;
  assign c0_eff   = sub ? ~cin : cin;

  always_comb begin
    kpg_enc = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      kpg_enc[2*i +: 2] = {a[i] & b_eff[i], a[i] | b_eff[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_side <= '0;
      s0_kpg  <= '0;
    end else if (en) begin
      s0_side <= '{valid: accept, c0: c0_eff, op_a: a, op_b: b_eff};
      s0_kpg  <= kpg_enc;
    end
  end

  // Carry-in is folded into bit 0 so LEVELS levels resolve every carry.
  // The final level's register is the output register itself, which keeps
  // accept-to-output latency at ceil(LEVELS/REG_EVERY)+1.
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    logic [2*WIDTH-1:0] kpg_i;
    logic [2*WIDTH-1:0] kpg_o;
    logic [2*WIDTH-1:0] kpg_nx;
    side_t              side_i;
    side_t              side_nx;

    if (k == 0) begin : g_src
      assign kpg_i  = {s0_kpg[2*WIDTH-1:2], kpg_combine(s0_kpg[1:0], {2{s0_side.c0}})};
      assign side_i = s0_side;
    end else begin : g_src
      assign kpg_i  = g_lvl[k-1].kpg_nx;
      assign side_i = g_lvl[k-1].side_nx;
    end

    kpg_prefix_level #(
      .WIDTH(WIDTH),
      .DIST (1 << k)
    ) u_level (
      .kpg_in (kpg_i),
      .kpg_out(kpg_o)
    );

    if ((((k + 1) % REG_EVERY) == 0) && (k != LEVELS - 1)) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          kpg_nx  <= '0;
          side_nx <= '0;
        end else if (en) begin
          kpg_nx  <= kpg_o;
          side_nx <= side_i;
        end
      end
    end else begin : g_pass
      assign kpg_nx  = kpg_o;
      assign side_nx = side_i;
    end
  end

  side_t              fin;
  logic [2*WIDTH-1:0] grp;
  logic [WIDTH:0]     carry;
  logic [WIDTH-1:0]   sum_d;

  assign fin = g_lvl[LEVELS-1].side_nx;
  assign grp = g_lvl[LEVELS-1].kpg_nx;

  always_comb begin
    carry    = '0;
    carry[0] = fin.c0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      carry[i+1] = (grp[2*i +: 2] == KPG_GEN);
    end
    sum_d = fin.op_a ^ fin.op_b ^ carry[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (en) begin
      out_valid <= fin.valid;
      sum       <= sum_d;
      cout      <= carry[WIDTH];
      ovf       <= (fin.op_a[WIDTH-1] == fin.op_b[WIDTH-1]) && (sum_d[WIDTH-1] != fin.op_a[WIDTH-1]);
      zero      <= ~|sum_d;
    end
  end

endmodule

// File: doc/pipelined_prefix_adder.md
Name: pipelined_prefix_adder

Overview:
- Parametrised, pipelined Kogge-Stone (KPG) parallel-prefix adder/subtractor for the ALU datapath.
- Generalises the fixed 16-bit combinational prefix adder in four ways: configurable width, register insertion between prefix levels, add/subtract mode with carry-in, and valid/ready handshakes on both sides.
- Produces sum, carry-out, signed overflow and zero flags.
- Feeds the ALU result mux and the multiplier's final carry-propagate stage.

Parameters:
- WIDTH, 16, operand width; power of two, 8..64.
- REG_EVERY, 1, pipeline register after every REG_EVERY prefix levels; 1..LEVELS.
- LEVELS, derived log2(WIDTH), number of prefix levels; not overridable.
- LAT, derived ceil(LEVELS/REG_EVERY)+1, accept-to-output latency in cycles (WIDTH=16: REG_EVERY=1 gives 5, 2 gives 3, 4 gives 2).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  block can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0 = add, 1 = subtract
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  raw carry out of MSB
- ovf  out  1  signed overflow
- zero  out  1  sum == 0

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: out_valid=0, sum=0, cout=0, ovf=0, zero=0, all internal valid bits 0. in_ready=1 in the cycle after rst deasserts.
- Reset mid-operation discards all in-flight operations; nothing emerges afterwards.
- Arithmetic:
  - Effective b' = sub ? ~b : b.
  - Effective c0 = sub ? ~cin : cin.
  - Add: result = a + b + cin. Sub: result = a - b - cin.
  - cout = carry out of bit WIDTH-1. In sub mode cout=1 means no borrow.
  - ovf = (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]).
  - zero = ~|sum.
- Stage 0 (at accept):
  - Register per-bit KPG pairs from a and b': kill=00, propagate=01, generate=11.
  - Register c0 as bit -1 generate/kill.
  - Register raw a and b' for the final XOR and ovf.
- Prefix levels: level k combines bit i with bit i-2^k (i ≥ 2^k), Kogge-Stone.
  - Register after levels REG_EVERY, 2·REG_EVERY, …; the final level is always registered.
  - Operands and flags travel in lock-step.
- Final stage: the sum XOR and flags are computed from the last prefix register and registered into the output register.
- Flow control:
  - Global enable en = !out_valid || out_ready.
  - in_ready = en, combinational; there is no combinational path from in_valid to in_ready.
  - Accept occurs when in_valid && in_ready.
  - When en=1, every stage shifts one position and stage 0 loads the accept bit as its valid.
  - When en=0, all stages hold.
- Bubbles propagate as invalid stages; they are not squeezed out.
- Throughput is one result per cycle when out_ready is held at 1.
- Latency: result for an accept in cycle t is presented with out_valid=1 in cycle t+LAT, provided en was 1 in every intervening cycle. Each en=0 cycle adds one.
- Output hold: while out_valid && !out_ready, sum/cout/ovf/zero remain stable.
- Ordering: results leave in acceptance order. There is no loss and no duplication.
- Boundary cases:
  - WIDTH=8 with REG_EVERY=LEVELS gives LAT=2.
  - Simultaneous accept and output-drain is allowed in the same cycle.
  - sub=1, cin=0, a=b gives zero=1, cout=1.

Decomposition:
- Package prefix_adder_pkg:
  - KPG encoding constants (KPG_KILL, KPG_PROP, KPG_GEN).
  - KPG combine function (upper dominates unless propagate).
  - clog2 function and latency function lat(WIDTH, REG_EVERY), shared with the bench.
- Sub-module kpg_prefix_level:
  - One combinational Kogge-Stone level, parameters WIDTH and DIST.
  - Instantiated LEVELS times via generate.
  - Registers stay in the top module.

Test Plan:
- WIDTH=16, REG_EVERY=1, a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> 5 cycles after accept: sum=0x0000, cout=1, zero=1, ovf=0.
- a=0x7FFF, b=0x0001, add -> sum=0x8000, ovf=1, cout=0. Then a=0x8000, b=0x0001, sub -> sum=0x7FFF, ovf=1, cout=1.
- sub=1, a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0. Same with cin=1 -> sum=0xFFFD.
- Back-to-back accepts of 8 operations with out_ready pattern 1,0,0,1,0,1,1,… -> in_ready follows en, outputs held stable while stalled, all 8 results correct and in order.
- Assert rst for one cycle while 3 operations are in flight -> out_valid=0 the next cycle, no stale result ever appears, a new operation completes with nominal LAT.
- WIDTH=8, REG_EVERY=2 and WIDTH=32, REG_EVERY=3: 10k random a/b/cin/sub values with random backpressure -> all fields match the golden model and measured latency equals lat().
